// File: rtl/keypoint_scan_ctrl.sv
// keypoint_scan_ctrl: steps a 3-row DoG window over the image interior and serialises
//   each column's extremum hits through one shared filter into N_SCALE keypoint banks.
// Latency: first DETECT 4 cycles after start; a keypoint write lands 1 cycle after acceptance.
// Backpressure: none; a keypoint with no free bank is dropped and counted in drop_cnt_o.
// Build option: define KP_SPILL_EN to let a keypoint whose home bank is full spill into
//   the next non-full bank (s+1, s+2, ... modulo N_SCALE); undefined, it is dropped.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   start_i, filter_on_i     frame start (honoured in IDLE only), filter enable latched at start
//   busy_o, done_o           not-IDLE flag, one-cycle end-of-frame pulse
//   row_addr_o, buffer_we_o  bottom-row SRAM address (centre row is row_addr_o-1), line-buffer shift
//   cur_col_o, kp_hit_i      column under test, per-scale extremum flags for that column
//   filt_sel_o, filt_pass_i  scale routed to the shared filter, its verdict
//   kp_we_o, kp_addr_o       one-hot bank write enable, flattened per-bank write addresses
//   kp_din_o, kp_full_o      {centre_row, cur_col} write data, per-bank full flags
//   drop_cnt_o               saturating count of dropped keypoints
module keypoint_scan_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int BORDER   = 8,
  parameter int N_SCALE  = 2,
  parameter int KP_DEPTH = 2048,
  parameter int ROW_W    = 9,
  parameter int COL_W    = 10,
  parameter int KP_AW    = 11,
  localparam int SEL_W   = (N_SCALE > 1) ? $clog2(N_SCALE) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     filter_on_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ROW_W-1:0]         row_addr_o,
  output logic                     buffer_we_o,
  output logic [COL_W-1:0]         cur_col_o,
  input  logic [N_SCALE-1:0]       kp_hit_i,
  output logic [SEL_W-1:0]         filt_sel_o,
  input  logic                     filt_pass_i,
  output logic [N_SCALE-1:0]       kp_we_o,
  output logic [N_SCALE*KP_AW-1:0] kp_addr_o,
  output logic [ROW_W+COL_W-1:0]   kp_din_o,
  output logic [N_SCALE-1:0]       kp_full_o,
  output logic [15:0]              drop_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRIME0, S_PRIME1, S_PRIME2, S_DETECT, S_SERVE, S_ROW_ADV, S_BUF, S_DONE
  } state_t;

  localparam int TGT_W = SEL_W + 1;
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(BORDER - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - BORDER);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(BORDER);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - BORDER - 1);
  localparam logic [KP_AW-1:0] ADDR_LAST = KP_AW'(KP_DEPTH - 1);

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [N_SCALE-1:0]   pend_q, pend_d;
  logic                 filt_en_q, filt_en_d;
  logic                 clr_banks;
  logic                 adv_col;
  logic [SEL_W-1:0]     sel;

  logic [N_SCALE-1:0]   kp_we_q;
  logic [ROW_W+COL_W-1:0] kp_din_q;
  logic [KP_AW-1:0]     kp_addr_q [N_SCALE];
  logic [N_SCALE-1:0]   kp_full_q;
  logic [15:0]          drop_q;

  logic [N_SCALE-1:0]   full_eff;
  logic                 accept;
  logic                 tgt_ok;
  logic [TGT_W-1:0]     tgt;

  // Lowest pending scale is served first.
  always_comb begin
    sel = '0;
    for (int s = N_SCALE - 1; s >= 0; s--) begin
      if (pend_q[s]) sel = SEL_W'(s);
    end
  end

  // A write in flight to the last address makes the bank full for the next acceptance,
  // since back-to-back SERVE cycles decide before kp_full_q has caught up.
  always_comb begin
    full_eff = '0;
    for (int b = 0; b < N_SCALE; b++) begin
      full_eff[b] = kp_full_q[b] | (kp_we_q[b] & (kp_addr_q[b] == ADDR_LAST));
    end
  end

  assign accept = (state_q == S_SERVE) && (!filt_en_q || filt_pass_i);

`ifdef KP_SPILL_EN
  // Rotate so bit j is the bank (sel + j) mod N_SCALE; first free one wins.
  logic [N_SCALE-1:0] full_rot;
  always_comb begin
    full_rot = N_SCALE'({full_eff, full_eff} >> sel);
    tgt_ok   = 1'b0;
    tgt      = '0;
    for (int j = 0; j < N_SCALE; j++) begin
      if (!tgt_ok && !full_rot[j]) begin
        tgt_ok = 1'b1;
        tgt    = {1'b0, sel} + TGT_W'(j);
      end
    end
    if (tgt >= TGT_W'(N_SCALE)) tgt = tgt - TGT_W'(N_SCALE);
  end
`else
  always_comb begin
    tgt_ok = !full_eff[sel];
    tgt    = {1'b0, sel};
  end
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    pend_d      = pend_q;
    filt_en_d   = filt_en_q;
    clr_banks   = 1'b0;
    adv_col     = 1'b0;
    busy_o      = (state_q != S_IDLE);
    done_o      = 1'b0;
    buffer_we_o = 1'b0;
    filt_sel_o  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          row_d     = ROW_FIRST;
          filt_en_d = filter_on_i;
          clr_banks = 1'b1;
          state_d   = S_PRIME0;
        end
      end
      S_PRIME0: begin
        row_d   = ROW_W'(BORDER);
        state_d = S_PRIME1;
      end
      S_PRIME1: begin
        buffer_we_o = 1'b1;
        row_d       = ROW_W'(BORDER + 1);
        state_d     = S_PRIME2;
      end
      S_PRIME2: begin
        buffer_we_o = 1'b1;
        col_d       = COL_FIRST;
        state_d     = S_DETECT;
      end
      S_DETECT: begin
        pend_d = kp_hit_i;
        if (kp_hit_i != '0) state_d = S_SERVE;
        else                adv_col = 1'b1;
      end
      S_SERVE: begin
        filt_sel_o = sel;
        pend_d     = pend_q & ~(N_SCALE'(1) << sel);
        if (pend_d == '0) adv_col = 1'b1;
      end
      S_ROW_ADV: begin
        if (row_q == ROW_LAST) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          col_d   = COL_FIRST;
          state_d = S_BUF;
        end
      end
      S_BUF: begin
        buffer_we_o = 1'b1;
        state_d     = S_DETECT;
      end
      S_DONE: begin
        done_o  = 1'b1;
        row_d   = ROW_FIRST;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (adv_col) begin
      if (col_q < COL_LAST) begin
        col_d   = col_q + COL_W'(1);
        state_d = S_DETECT;
      end else begin
        state_d = S_ROW_ADV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= ROW_FIRST;
      col_q     <= COL_FIRST;
      pend_q    <= '0;
      filt_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pend_q    <= pend_d;
      filt_en_q <= filt_en_d;
    end
  end

  // Bank write port: address advances at the end of each write cycle so kp_addr_o
  // shows the address being written while kp_we_o is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kp_we_q   <= '0;
      kp_din_q  <= '0;
      kp_full_q <= '0;
      drop_q    <= '0;
      for (int b = 0; b < N_SCALE; b++) kp_addr_q[b] <= '0;
    end else if (clr_banks) begin
      kp_we_q   <= '0;
      kp_full_q <= '0;
      drop_q    <= '0;
      for (int b = 0; b < N_SCALE; b++) kp_addr_q[b] <= '0;
    end else begin
      kp_we_q <= '0;
      for (int b = 0; b < N_SCALE; b++) begin
        if (kp_we_q[b]) begin
          if (kp_addr_q[b] == ADDR_LAST) begin
            kp_addr_q[b] <= '0;
            kp_full_q[b] <= 1'b1;
          end else begin
            kp_addr_q[b] <= kp_addr_q[b] + KP_AW'(1);
          end
        end
      end
      if (accept) begin
        if (tgt_ok) begin
          kp_we_q  <= N_SCALE'(1) << tgt;
          kp_din_q <= {row_q - ROW_W'(1), col_q};
        end else if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 16'd1;
        end
      end
    end
  end

  always_comb begin
    kp_addr_o = '0;
    for (int b = 0; b < N_SCALE; b++) kp_addr_o[b*KP_AW +: KP_AW] = kp_addr_q[b];
  end

  assign row_addr_o = row_q;
  assign cur_col_o  = col_q;
  assign kp_we_o    = kp_we_q;
  assign kp_din_o   = kp_din_q;
  assign kp_full_o  = kp_full_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_keypoint_scan_ctrl.sv
// Scoreboard bench for keypoint_scan_ctrl on a reduced image. A frame-level reference
// model walks the interior pixel by pixel, predicting every keypoint write (bank, address,
// data, cycle), every buffer_we strobe, the done cycle and the end-of-frame bank state.
module tb_keypoint_scan_ctrl;
  localparam int IW = 20, IH = 12, BD = 2, NS = 2, DEP = 4;
  localparam int RW = 4, CW = 5, AW = 2, SW = 1;
  localparam int LIMIT = 2000;
`ifdef KP_SPILL_EN
  localparam int TRIES = NS;
`else
  localparam int TRIES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, rst_q;
  logic start, filter_on, busy, done, buffer_we, filt_pass;
  logic [RW-1:0] row_addr;
  logic [CW-1:0] cur_col;
  logic [NS-1:0] kp_hit, kp_we, kp_full;
  logic [SW-1:0] filt_sel;
  logic [NS*AW-1:0] kp_addr;
  logic [RW+CW-1:0] kp_din;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  keypoint_scan_ctrl #(
    .IMG_W(IW), .IMG_H(IH), .BORDER(BD), .N_SCALE(NS), .KP_DEPTH(DEP),
    .ROW_W(RW), .COL_W(CW), .KP_AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .filter_on_i(filter_on),
    .busy_o(busy), .done_o(done), .row_addr_o(row_addr), .buffer_we_o(buffer_we),
    .cur_col_o(cur_col), .kp_hit_i(kp_hit), .filt_sel_o(filt_sel), .filt_pass_i(filt_pass),
    .kp_we_o(kp_we), .kp_addr_o(kp_addr), .kp_din_o(kp_din), .kp_full_o(kp_full),
    .drop_cnt_o(drop_cnt)
  );

  // Image-side stimulus: per-pixel hit flags and per-scale filter verdicts.
  logic [NS-1:0] hitmap  [IH][IW];
  logic [NS-1:0] passmap [IH][IW];
  assign kp_hit    = hitmap[int'(row_addr) - 1][cur_col];
  assign filt_pass = passmap[int'(row_addr) - 1][cur_col][filt_sel];

  typedef struct { int bank; int addr; int din; int cyc; } wr_t;
  typedef struct { logic [NS*AW-1:0] addr; int full; int drops; } fr_t;
  wr_t wq[$];
  int  bq[$];
  int  dq[$];
  fr_t fq[$];

  int cyc = 0;
  int n_vec = 0, n_bad = 0;
  int to_cnt = 0, to_seen = 0;
  bit post_done = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: sole checker; samples on the falling edge.
  always @(negedge clk) begin
    wr_t w;
    fr_t f;
    if (rst_q === 1'b0) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_row_addr", row_addr, BD - 1);
      chk("rst_cur_col", cur_col, BD);
      chk("rst_buffer_we", buffer_we, 0);
      chk("rst_filt_sel", filt_sel, 0);
      chk("rst_kp_we", kp_we, 0);
      chk("rst_kp_addr", kp_addr, 0);
      chk("rst_kp_din", kp_din, 0);
      chk("rst_kp_full", kp_full, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      wq.delete(); bq.delete(); dq.delete(); fq.delete();
      post_done = 0;
    end else if (rst_q === 1'b1) begin
      if (post_done) begin
        post_done = 0;
        if (fq.size() == 0) miss("frame_end");
        else begin
          f = fq.pop_front();
          chk("end_kp_addr", kp_addr, f.addr);
          chk("end_kp_full", kp_full, f.full);
          chk("end_drop_cnt", drop_cnt, f.drops);
          chk("end_busy", busy, 0);
          chk("end_pending_writes", wq.size(), 0);
          chk("end_pending_buffer_we", bq.size(), 0);
        end
      end
      if (kp_we != '0) begin
        chk("kp_we_onehot", $onehot(kp_we), 1);
        if (wq.size() == 0) miss("kp_write");
        else begin
          w = wq.pop_front();
          chk("kp_we_bank", kp_we, 1 << w.bank);
          chk("kp_write_cycle", cyc, w.cyc);
          chk("kp_din", kp_din, w.din);
          chk("kp_addr", (kp_addr >> (w.bank * AW)) & ((1 << AW) - 1), w.addr);
        end
      end
      if (buffer_we) begin
        if (bq.size() == 0) miss("buffer_we");
        else chk("buffer_we_cycle", cyc, bq.pop_front());
      end
      if (done) begin
        if (dq.size() == 0) miss("done");
        else chk("done_cycle", cyc, dq.pop_front());
        chk("busy_in_done", busy, 1);
        post_done = 1;
      end
    end
    if (to_cnt != to_seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles, expected a done pulse", LIMIT);
      to_seen = to_cnt;
    end
  end

  // Reference model: the accepting edge is e; the scan visits centre rows BD..IH-BD-1 and
  // columns BD..IW-BD-1 in order. A column with k hits costs 1+k cycles; its i-th hit is
  // served i cycles after DETECT and written one cycle later. Rows end with ROW_ADV + BUF,
  // the last row with ROW_ADV + DONE.
  task automatic build_frame(input bit fon, input int e);
    int fill [NS];
    int drops, t, k, b;
    bit placed;
    wr_t w;
    fr_t f;
    for (int i = 0; i < NS; i++) fill[i] = 0;
    drops = 0;
    t = e + 3;
    bq.push_back(e + 1);
    bq.push_back(e + 2);
    for (int r = BD; r <= IH - BD - 1; r++) begin
      for (int c = BD; c <= IW - BD - 1; c++) begin
        k = 0;
        for (int s = 0; s < NS; s++) begin
          if (hitmap[r][c][s]) begin
            k++;
            if (!fon || passmap[r][c][s]) begin
              placed = 0;
              for (int j = 0; j < TRIES; j++) begin
                b = (s + j) % NS;
                if (!placed && fill[b] < DEP) begin
                  w.bank = b; w.addr = fill[b]; w.din = (r << CW) | c; w.cyc = t + k + 1;
                  wq.push_back(w);
                  fill[b]++;
                  placed = 1;
                end
              end
              if (!placed && drops < 65535) drops++;
            end
          end
        end
        t += 1 + k;
      end
      if (r == IH - BD - 1) dq.push_back(t + 1);
      else begin
        bq.push_back(t + 1);
        t += 2;
      end
    end
    f.addr = '0;
    f.full = 0;
    for (int i = 0; i < NS; i++) begin
      f.addr |= (NS*AW)'((fill[i] % DEP) << (i * AW));
      if (fill[i] == DEP) f.full |= 1 << i;
    end
    f.drops = drops;
    fq.push_back(f);
  endtask

  // pulse_at: cycle index of a one-cycle start pulse while busy (0 = none);
  // abort_at: cycle index at which reset is asserted mid-frame (0 = none).
  task automatic run_frame(input bit fon, input int pulse_at, input int abort_at);
    int e;
    bit seen;
    @(posedge clk); #2;
    start = 1'b1;
    filter_on = fon;
    e = cyc + 1;
    build_frame(fon, e);
    seen = 0;
    for (int i = 1; i <= LIMIT && !seen; i++) begin
      @(posedge clk); #2;
      start = (i == pulse_at);
      if (i == pulse_at) filter_on = ~fon;
      if (abort_at != 0 && i == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        return;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    if (!seen) to_cnt++;
    @(posedge clk); #2;
    @(posedge clk); #2;
  endtask

  task automatic clear_maps();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        hitmap[r][c]  = '0;
        passmap[r][c] = '0;
      end
  endtask

  task automatic random_maps(input int pct);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        for (int s = 0; s < NS; s++) begin
          hitmap[r][c][s]  = ($urandom_range(99) < pct);
          passmap[r][c][s] = $urandom_range(1);
        end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    filter_on = 1'b0;
    clear_maps();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    run_frame(1'b0, 0, 0);                         // empty frame: strobes and done only
    hitmap[BD][10] = 2'b11;
    run_frame(1'b0, 0, 0);                         // two hits, unfiltered: bank0 then bank1
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) passmap[r][c] = 2'b10;
    run_frame(1'b1, 0, 0);                         // filtered: only scale 1 passes
    clear_maps();
    for (int i = 0; i < 6; i++) hitmap[BD + i / 3][BD + 3 * (i % 3)] = 2'b01;
    run_frame(1'b0, 0, 0);                         // scale-0 overflow: spill or drop
    random_maps(30);
    run_frame(1'(($urandom_range(1))), 0, 40);     // reset mid-row
    for (int n = 0; n < 6; n++) begin
      random_maps(5 + 10 * (n % 4));
      run_frame(1'(($urandom_range(1))), $urandom_range(5, 100), 0);
    end
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
